michi_turn_controller: RTL and testbench
========================================

MICHI_TURN_CONTROLLER -- requirements
Module: michi_turn_controller

Interface
REQ-001 The block SHALL have parameter FIRST_PLAYER, default 0, meaning the player who moves first after reset or new game (0 = X, 1 = O).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port new_game, input, 1, a request to clear the board and restart.
REQ-005 The block SHALL have port move_valid, input, 1, which is high when a move is offered.
REQ-006 The block SHALL have port move_pos, input, 4, the cell index of the offered move (0..8, row-major).
REQ-007 The block SHALL have port move_ready, output, 1, which is high when the block can accept a move.
REQ-008 The block SHALL have port sel, output, 1, the current player and the demux select that routes the move strobe (0 = X, 1 = O).
REQ-009 The block SHALL have port board_x, output, 9, the X occupancy bitmap with bit i = cell i.
REQ-010 The block SHALL have port board_o, output, 9, the O occupancy bitmap.
REQ-011 The block SHALL have port move_count, output, 4, the number of accepted moves (0..9).
REQ-012 The block SHALL have port illegal, output, 1, a one-cycle pulse when a move is rejected.
REQ-013 The block SHALL have port winner, output, 2, the game result: 00 none, 01 X, 10 O, 11 draw.
REQ-014 The block SHALL have port game_over, output, 1, which is high while the FSM is in DONE.

Function
REQ-015 The FSM SHALL have exactly three states: PLAY, EVAL and DONE.
REQ-016 In PLAY the block SHALL drive move_ready = 1; in EVAL and DONE it SHALL drive move_ready = 0.
REQ-017 A move SHALL be accepted when move_valid and move_ready are both high at a rising edge and move_pos <= 8, and neither board_x nor board_o has bit move_pos set.
REQ-018 On an accepted move, the bit move_pos SHALL be set in the board selected by sel, move_count SHALL increment, and the FSM SHALL go to EVAL, all at the same edge.
REQ-019 A move offered in PLAY with move_pos > 8 or to an occupied cell SHALL leave the boards, move_count and sel unchanged, pulse illegal high for the next cycle only, and keep the FSM in PLAY.
REQ-020 In EVAL the block SHALL check the 8 lines (3 rows, 3 columns, 2 diagonals) of the board of the player who just moved (sel).
REQ-021 From EVAL, on a win the FSM SHALL go to DONE with winner = 01 if sel = 0 or 10 if sel = 1, and sel SHALL stay unchanged.
REQ-022 From EVAL, with no win and move_count = 9, the FSM SHALL go to DONE with winner = 11.
REQ-023 From EVAL, with no win and move_count < 9, sel SHALL toggle and the FSM SHALL return to PLAY.
REQ-024 The result of an accepted move SHALL be visible two edges after acceptance: the board is updated at edge N+1, and winner, game_over and the toggled sel are updated at edge N+2.
REQ-025 A win on the 9th move SHALL report the winner, not a draw.
REQ-026 In DONE, move_valid SHALL be ignored: no state change and no illegal pulse.
REQ-027 A new_game sampled high in any state SHALL, at the next edge, clear board_x, board_o, move_count, winner and illegal, set sel = FIRST_PLAYER, and put the FSM in PLAY.
REQ-028 When new_game and move_valid are high together, new_game SHALL take priority and the move SHALL be discarded.
REQ-029 A move_valid held high across consecutive PLAY cycles SHALL count as one offer per edge; after an acceptance, no second move SHALL be accepted until the FSM returns to PLAY.

Reset
REQ-030 When rst_n is low at a rising edge, the block SHALL enter PLAY and set board_x = 0, board_o = 0, move_count = 0, winner = 00, illegal = 0 and sel = FIRST_PLAYER; game_over SHALL then read 0 and move_ready SHALL read 1.
REQ-031 rst_n SHALL take priority over new_game and move_valid.
REQ-032 A reset asserted while the FSM is in EVAL or DONE SHALL discard the pending evaluation or result.
REQ-033 The block SHALL have no asynchronous reset path.

Verification
REQ-034 Reset, then moves 0 (X), 3 (O), 1 (X), 4 (O), 2 (X) -> after the last move plus 2 cycles: winner = 01, game_over = 1, board_x = 0x007, board_o = 0x018, move_count = 5.
REQ-035 Reset, then X plays 0 and O plays 0 -> the second move raises illegal for 1 cycle, board_o stays 0, sel stays 1, move_count stays 1.
REQ-036 move_pos = 9 in PLAY -> illegal pulses, nothing else changes; move_pos = 15 -> same result.
REQ-037 Draw sequence 0, 1, 2, 4, 3, 5, 7, 6, 8 -> winner = 11, move_count = 9, game_over = 1; then a move_valid in DONE -> no illegal pulse and no change.
REQ-038 new_game asserted in the same cycle as a legal move_valid while in PLAY -> the move is discarded and all state is cleared; also rst_n low during EVAL -> PLAY with empty boards on the next cycle.
REQ-039 With FIRST_PLAYER = 1 -> sel = 1 after reset, and the first accepted move sets board_o.

Source files
------------

// File: rtl/michi_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : michi_turn_controller
// Purpose  : Tic-tac-toe turn sequencer: accepts moves, tracks both boards,
//            detects wins and draws, and selects the player to move.
// Revision : 1.0 - initial release
// ============================================================================
module michi_turn_controller #(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       sel,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic [3:0] move_count,
    output logic       illegal,
    output logic [1:0] winner,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_last_cell = 4'd8;
    localparam logic [3:0] c_full      = 4'd9;

    state_t     r_state;
    logic       r_move_ready;
    logic       r_sel;
    logic [8:0] r_board_x;
    logic [8:0] r_board_o;
    logic [3:0] r_move_count;
    logic       r_illegal;
    logic [1:0] r_winner;
    logic       r_game_over;

    logic [8:0] w_pos_onehot;
    logic       w_pos_free;
    logic       w_legal;
    logic [8:0] w_mover_board;
    logic       w_win;

    function automatic logic f_has_line(input logic [8:0] b);
        f_has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) |
                     (b[6] & b[7] & b[8]) | (b[0] & b[3] & b[6]) |
                     (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
                     (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Positions above 8 shift the one-hot out of range; the explicit bound
    // check still rejects them.
    assign w_pos_onehot  = 9'b1 << move_pos;
    assign w_pos_free    = ((r_board_x | r_board_o) & w_pos_onehot) == 9'd0;
    assign w_legal       = (move_pos <= c_last_cell) && w_pos_free;
    assign w_mover_board = r_sel ? r_board_o : r_board_x;
    assign w_win         = f_has_line(w_mover_board);

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            r_state      <= ST_PLAY;
            r_move_ready <= 1'b1;
            r_sel        <= FIRST_PLAYER;
            r_board_x    <= 9'd0;
            r_board_o    <= 9'd0;
            r_move_count <= 4'd0;
            r_illegal    <= 1'b0;
            r_winner     <= 2'b00;
            r_game_over  <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_PLAY: begin
                    if (move_valid) begin
                        if (w_legal) begin
                            if (r_sel) r_board_o <= r_board_o | w_pos_onehot;
                            else       r_board_x <= r_board_x | w_pos_onehot;
                            r_move_count <= r_move_count + 4'd1;
                            r_move_ready <= 1'b0;
                            r_state      <= ST_EVAL;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    // A completed line wins even when the board is full.
                    if (w_win) begin
                        r_winner    <= r_sel ? 2'b10 : 2'b01;
                        r_game_over <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_move_count == c_full) begin
                        r_winner    <= 2'b11;
                        r_game_over <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_sel        <= ~r_sel;
                        r_move_ready <= 1'b1;
                        r_state      <= ST_PLAY;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state      <= ST_PLAY;
                    r_move_ready <= 1'b1;
                    r_game_over  <= 1'b0;
                end
            endcase
        end
    end

    assign move_ready = r_move_ready;
    assign sel        = r_sel;
    assign board_x    = r_board_x;
    assign board_o    = r_board_o;
    assign move_count = r_move_count;
    assign illegal    = r_illegal;
    assign winner     = r_winner;
    assign game_over  = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_michi_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_michi_turn_controller
// Purpose  : Self-checking bench: cell-array reference model plus directed
//            scenarios and randomized play.
// Revision : 1.0 - initial release
// ============================================================================
module tb_michi_turn_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;

    logic       move_ready, sel, illegal, game_over;
    logic [8:0] board_x, board_o;
    logic [3:0] move_count;
    logic [1:0] winner;

    logic       o1_ready, o1_sel, o1_illegal, o1_over;
    logic [8:0] o1_bx, o1_bo;
    logic [3:0] o1_count;
    logic [1:0] o1_winner;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    michi_turn_controller #(.FIRST_PLAYER(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(move_ready), .sel(sel),
        .board_x(board_x), .board_o(board_o), .move_count(move_count),
        .illegal(illegal), .winner(winner), .game_over(game_over)
    );

    michi_turn_controller #(.FIRST_PLAYER(1'b1)) u_dut_o (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(o1_ready), .sel(o1_sel),
        .board_x(o1_bx), .board_o(o1_bo), .move_count(o1_count),
        .illegal(o1_illegal), .winner(o1_winner), .game_over(o1_over)
    );

    always #5 clk = ~clk;

    // Reference model: cells hold 0 empty, 1 X, 2 O.
    int m_cells[9];
    int m_player;      // 0 = X, 1 = O
    int m_count;
    int m_result;      // 0 none, 1 X, 2 O, 3 draw
    bit m_illegal;
    bit m_judging;     // a move was taken and its outcome is not yet known
    bit m_finished;

    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit owns_line(int who);
        for (int l = 0; l < 8; l++)
            if (m_cells[lines[l][0]] == who && m_cells[lines[l][1]] == who &&
                m_cells[lines[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n || new_game) begin
            foreach (m_cells[i]) m_cells[i] = 0;
            m_player = 0; m_count = 0; m_result = 0;
            m_illegal = 0; m_judging = 0; m_finished = 0;
        end else begin
            m_illegal = 0;
            if (m_finished) begin
                // finished game ignores offers
            end else if (m_judging) begin
                m_judging = 0;
                if (owns_line(m_player + 1)) begin
                    m_result = m_player + 1; m_finished = 1;
                end else if (m_count == 9) begin
                    m_result = 3; m_finished = 1;
                end else begin
                    m_player = 1 - m_player;
                end
            end else if (move_valid) begin
                if (move_pos < 9 && m_cells[move_pos] == 0) begin
                    m_cells[move_pos] = m_player + 1;
                    m_count++;
                    m_judging = 1;
                end else begin
                    m_illegal = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [8:0] ex, eo;
            ex = '0; eo = '0;
            for (int i = 0; i < 9; i++) begin
                ex[i] = (m_cells[i] == 1);
                eo[i] = (m_cells[i] == 2);
            end
            chk("board_x", 16'(board_x), 16'(ex));
            chk("board_o", 16'(board_o), 16'(eo));
            chk("sel", 16'(sel), 16'(m_player));
            chk("move_count", 16'(move_count), 16'(m_count));
            chk("illegal", 16'(illegal), 16'(m_illegal));
            chk("winner", 16'(winner), 16'(m_result));
            chk("game_over", 16'(game_over), 16'(m_finished));
            chk("move_ready", 16'(move_ready), 16'(!m_judging && !m_finished));
        end
    end

    logic ill_seen;

    // Called at a negedge; returns two negedges later with the outcome visible.
    task automatic offer(input int p);
        move_valid = 1'b1;
        move_pos   = 4'(p);
        @(negedge clk);
        ill_seen   = illegal;
        move_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    int xwin[5]  = '{0, 3, 1, 4, 2};
    int drawq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        chk("rst ready", 16'(move_ready), 16'd1);
        chk("rst sel", 16'(sel), 16'd0);
        chk("rst over", 16'(game_over), 16'd0);
        chk("rst o sel", 16'(o1_sel), 16'd1);

        // X wins on the top row
        foreach (xwin[i]) begin
            offer(xwin[i]);
            if (i == 0) begin
                chk("fp1 board_o", 16'(o1_bo), 16'h001);
                chk("fp1 board_x", 16'(o1_bx), 16'h000);
            end
        end
        chk("xwin winner", 16'(winner), 16'd1);
        chk("xwin over", 16'(game_over), 16'd1);
        chk("xwin bx", 16'(board_x), 16'h007);
        chk("xwin bo", 16'(board_o), 16'h018);
        chk("xwin count", 16'(move_count), 16'd5);

        // Occupied cell
        do_reset();
        offer(0);
        offer(0);
        chk("occ illegal", 16'(ill_seen), 16'd1);
        chk("occ pulse end", 16'(illegal), 16'd0);
        chk("occ bo", 16'(board_o), 16'h000);
        chk("occ sel", 16'(sel), 16'd1);
        chk("occ count", 16'(move_count), 16'd1);

        // Out-of-range positions
        offer(9);
        chk("pos9 illegal", 16'(ill_seen), 16'd1);
        offer(15);
        chk("pos15 illegal", 16'(ill_seen), 16'd1);
        chk("pos15 count", 16'(move_count), 16'd1);

        // Draw, then offer in DONE
        do_new_game();
        foreach (drawq[i]) offer(drawq[i]);
        chk("draw winner", 16'(winner), 16'd3);
        chk("draw count", 16'(move_count), 16'd9);
        chk("draw over", 16'(game_over), 16'd1);
        chk("draw bx", 16'(board_x), 16'h18D);
        chk("draw bo", 16'(board_o), 16'h072);
        offer(4);
        chk("done no illegal", 16'(ill_seen), 16'd0);
        chk("done count", 16'(move_count), 16'd9);

        // new_game beats a legal move
        do_new_game();
        offer(4);
        new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd5;
        @(negedge clk);
        new_game = 1'b0; move_valid = 1'b0;
        chk("ng bo", 16'(board_o), 16'h000);
        chk("ng bx", 16'(board_x), 16'h000);
        chk("ng count", 16'(move_count), 16'd0);

        // Reset during evaluation
        move_valid = 1'b1; move_pos = 4'd4;
        @(negedge clk);
        move_valid = 1'b0;
        chk("eval ready", 16'(move_ready), 16'd0);
        do_reset();
        chk("rst eval bx", 16'(board_x), 16'h000);
        chk("rst eval ready", 16'(move_ready), 16'd1);

        // Randomized play
        for (int c = 0; c < 4000; c++) begin
            rst_n      = ($urandom % 300) != 0;
            new_game   = (($urandom % 80) == 0) || (game_over && ($urandom % 4) == 0);
            move_valid = ($urandom % 3) != 0;
            move_pos   = (($urandom % 8) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
            @(negedge clk);
        end
        move_valid = 1'b0; new_game = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
